router_sync_nch: RTL and testbench

//  Parametrised router synchroniser: latches the packet destination address and routes
//  the write enable and full flag for a NUM_CH-channel router. Drives per-channel valid

---
 rtl/router_sync_nch.sv | 115 +++++++++++
 tb/tb_router_sync_nch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_nch.sv
// Router synchroniser: captures the destination address, steers write enable and full flag,
// and raises per-channel soft resets on stalled FIFOs. Optional macro: SYNC_TIMEOUT_PROG_EN.
module router_sync_nch #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] din,
    input  logic              detect_addr,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
`ifdef SYNC_TIMEOUT_PROG_EN
    input  logic [CNT_W-1:0]  timeout_cfg,
`endif
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    localparam logic [ADDR_W:0]  NumChL   = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] TimeoutL = CNT_W'(TIMEOUT);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_err_q, addr_err_d;
    logic              addr_ok;
    logic [CNT_W-1:0]  thr, thr_m1;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] soft_q, soft_d;

    // Address capture
    always_comb begin
        addr_d     = addr_q;
        addr_err_d = 1'b0;
        if (detect_addr) begin
            addr_d     = din;
            addr_err_d = !({1'b0, din} < NumChL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Out-of-range addresses select nothing, so the packet is dropped by the FIFOs
    always_comb begin
        addr_ok   = ({1'b0, addr_q} < NumChL);
        wr_en     = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ok && (addr_q == ADDR_W'(i))) begin
                wr_en[i]  = wr_en_reg;
                fifo_full = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    always_comb begin
`ifdef SYNC_TIMEOUT_PROG_EN
        thr = (timeout_cfg >= CNT_W'(2)) ? timeout_cfg : TimeoutL;
`else
        thr = TimeoutL;
`endif
        thr_m1 = thr - CNT_W'(1);
    end

    // >= rather than == so a live threshold decrease fires on the next idle cycle
    always_comb begin
        soft_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (empty[i] || rd_en[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr_m1) begin
                cnt_d[i]  = '0;
                soft_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            soft_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            soft_q <= soft_d;
        end
    end

    assign soft_reset = soft_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_nch.sv
// Self-checking bench for router_sync_nch: directed steps plus a randomized phase scored
// against an idle-run-length model of the timeout rule.
module tb_router_sync_nch;

    localparam int NCH = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     din;
    logic           detect_addr;
    logic           wr_en_reg;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] rd_en;
`ifdef SYNC_TIMEOUT_PROG_EN
    logic [5:0]     timeout_cfg;
`endif
    logic [NCH-1:0] wr_en;
    logic           fifo_full;
    logic [NCH-1:0] vld_out;
    logic [NCH-1:0] soft_reset;
    logic           addr_err;

    router_sync_nch #(.NUM_CH(NCH), .ADDR_W(2), .TIMEOUT(30), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .detect_addr (detect_addr),
        .wr_en_reg   (wr_en_reg),
        .full        (full),
        .empty       (empty),
        .rd_en       (rd_en),
`ifdef SYNC_TIMEOUT_PROG_EN
        .timeout_cfg (timeout_cfg),
`endif
        .wr_en       (wr_en),
        .fifo_full   (fifo_full),
        .vld_out     (vld_out),
        .soft_reset  (soft_reset),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: captured address, error pulse, and length of the current idle-valid run
    int             m_addr;
    logic           m_err;
    int             m_run  [NCH];
    logic [NCH-1:0] m_soft;
    int             pulses [NCH];

    function automatic int cur_t();
`ifdef SYNC_TIMEOUT_PROG_EN
        return (timeout_cfg >= 2) ? int'(timeout_cfg) : 30;
`else
        return 30;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_err  = 1'b0;
        m_soft = '0;
        for (int i = 0; i < NCH; i++) m_run[i] = 0;
    endtask

    task automatic check_comb(input string tag);
        logic [NCH-1:0] e_wr, e_vld;
        logic           e_ff;
        e_vld = ~empty;
        e_wr  = '0;
        e_ff  = 1'b0;
        if (m_addr < NCH) begin
            if (wr_en_reg) e_wr[m_addr] = 1'b1;
            e_ff = full[m_addr];
        end
        check({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr));
        check({tag, ".fifo_full"}, 32'(fifo_full), 32'(e_ff));
        check({tag, ".vld_out"}, 32'(vld_out), 32'(e_vld));
    endtask

    task automatic check_reg(input string tag);
        check({tag, ".soft_reset"}, 32'(soft_reset), 32'(m_soft));
        check({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
    endtask

    // Advance one clock: update model from inputs seen at the edge, then compare
    task automatic tick(input string tag);
        int t;
        @(posedge clk);
        t = cur_t();
        if (detect_addr) begin
            m_addr = int'(din);
            m_err  = (int'(din) >= NCH);
        end else begin
            m_err = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (empty[i] || rd_en[i]) begin
                m_run[i]  = 0;
                m_soft[i] = 1'b0;
            end else begin
                m_run[i]++;
                m_soft[i] = (m_run[i] % t == 0);
            end
            if (m_soft[i]) pulses[i]++;
        end
        #1;
        check_reg(tag);
        check_comb(tag);
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < NCH; i++) pulses[i] = 0;
    endtask

    initial begin
        logic [NCH-1:0] active;
        rst         = 1'b0;
        din         = '0;
        detect_addr = 1'b0;
        wr_en_reg   = 1'b0;
        full        = '0;
        empty       = '1;
        rd_en       = '0;
`ifdef SYNC_TIMEOUT_PROG_EN
        timeout_cfg = '0;
`endif
        model_reset();
        clear_pulses();

        // Reset held with inputs toggling: nothing registered may move
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            din         = 2'(k);
            detect_addr = 1'b1;
            empty       = 3'(k);
            full        = 3'(~k);
            @(posedge clk);
            #1;
            check("rst.soft_reset", 32'(soft_reset), 32'd0);
            check("rst.addr_err", 32'(addr_err), 32'd0);
            check("rst.wr_en", 32'(wr_en), 32'd0);
        end
        @(negedge clk);
        detect_addr = 1'b0;
        empty       = '1;
        full        = '0;
        rst         = 1'b1;
        tick("idle");

        // Routing to channel 2
        din         = 2'd2;
        detect_addr = 1'b1;
        tick("cap2");
        detect_addr = 1'b0;
        wr_en_reg   = 1'b1;
        full        = 3'b100;
        #1;
        check("route2.wr_en", 32'(wr_en), 32'b100);
        check("route2.fifo_full", 32'(fifo_full), 32'd1);
        tick("route2");

        // Capture and write in the same cycle: write uses the old address
        din         = 2'd0;
        detect_addr = 1'b1;
        #1;
        check("same_cycle.wr_en", 32'(wr_en), 32'b100);
        tick("cap0");
        detect_addr = 1'b0;
        #1;
        check("route0.wr_en", 32'(wr_en), 32'b001);

        // Bad address
        din         = 2'd3;
        detect_addr = 1'b1;
        tick("bad_cap");
        check("bad.addr_err_pulse", 32'(addr_err), 32'd1);
        detect_addr = 1'b0;
        full        = 3'b111;
        #1;
        check("bad.wr_en", 32'(wr_en), 32'd0);
        check("bad.fifo_full", 32'(fifo_full), 32'd0);
        tick("bad_next");
        check("bad.addr_err_clear", 32'(addr_err), 32'd0);
        wr_en_reg = 1'b0;
        full      = '0;

        // Timeout on channel 1: 65 idle-valid cycles, pulses at 30 and 60 only
        clear_pulses();
        empty = 3'b101;
        for (int k = 1; k <= 65; k++) begin
            tick("timeout");
            if (k == 30 || k == 60) check("timeout.pulse_at", 32'(soft_reset[1]), 32'd1);
        end
        check("timeout.count", 32'(pulses[1]), 32'd2);
        empty = '1;
        tick("timeout_end");

        // Read on the threshold cycle saves channel 0
        clear_pulses();
        empty = 3'b110;
        for (int k = 1; k <= 29; k++) tick("save");
        rd_en = 3'b001;
        tick("save_rd");
        check("save.no_pulse", 32'(soft_reset[0]), 32'd0);
        rd_en = '0;
        for (int k = 1; k <= 29; k++) tick("save_after");
        check("save.restart_no_pulse", 32'(pulses[0]), 32'd0);
        tick("save_30");
        check("save.restart_pulse", 32'(pulses[0]), 32'd1);
        empty = '1;
        tick("save_end");

`ifdef SYNC_TIMEOUT_PROG_EN
        clear_pulses();
        timeout_cfg = 6'd5;
        empty       = 3'b011;
        for (int k = 1; k <= 20; k++) tick("prog5");
        check("prog5.count", 32'(pulses[2]), 32'd4);
        empty = '1;
        tick("prog_flush");
        clear_pulses();
        timeout_cfg = 6'd1;
        empty       = 3'b011;
        for (int k = 1; k <= 31; k++) tick("prog1");
        check("prog1.fallback", 32'(pulses[2]), 32'd1);
        empty = '1;
        tick("prog_end");
        timeout_cfg = 6'd0;
`endif

        // Randomized phase: channels toggle between idle-valid and empty in long stretches
        active = '0;
        for (int k = 0; k < 1500; k++) begin
            din         = 2'($urandom_range(0, 3));
            detect_addr = ($urandom_range(0, 7) == 0);
            wr_en_reg   = $urandom_range(0, 1) == 1;
            full        = 3'($urandom);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 49) == 0) active[i] = ~active[i];
                rd_en[i] = active[i] && ($urandom_range(0, 63) == 0);
            end
            empty = ~active;
            #1;
            check_comb("rand.comb");
            tick("rand");
            if (k == 700) begin
                // Asynchronous reset mid-run clears everything at once
                rst = 1'b0;
                #1;
                model_reset();
                check("midrst.soft_reset", 32'(soft_reset), 32'd0);
                check("midrst.addr_err", 32'(addr_err), 32'd0);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
